// File: rtl/mult_ctrl.sv
// Bus-mapped controller that launches a handshake multiplier, tracks busy/done/timeout
// and captures the product. Optional irq output is enabled by defining MULT_CTRL_IRQ_EN.
module mult_ctrl #(
    parameter int TIMEOUT_CYCLES = 127
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cs,
    input  logic [4:0]  addr,
    input  logic        rd,
    input  logic        wr,
    input  logic [31:0] d_in,
    output logic [31:0] d_out,
    output logic        mult_init,
    output logic [15:0] mult_op_A,
    output logic [15:0] mult_op_B,
    input  logic        mult_done,
    input  logic [31:0] mult_result
`ifdef MULT_CTRL_IRQ_EN
    ,
    output logic        irq
`endif
);

    localparam int CNT_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    localparam logic [2:0] REG_OPA    = 3'd0;
    localparam logic [2:0] REG_OPB    = 3'd1;
    localparam logic [2:0] REG_CTRL   = 3'd2;
    localparam logic [2:0] REG_STATUS = 3'd3;
    localparam logic [2:0] REG_RESULT = 3'd4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LAUNCH = 2'd1,
        ST_WAIT   = 2'd2,
        ST_DRAIN  = 2'd3
    } state_t;

    state_t           state_r, next_state_s;
    logic [15:0]      opa_r, opb_r, opa_s, opb_s;
    logic [31:0]      result_r, result_s;
    logic [31:0]      d_out_r, rdata_s;
    logic [CNT_W-1:0] cnt_r, cnt_s, cnt_inc_s;
    logic             busy_r, busy_s;
    logic             done_r, done_s;
    logic             timeout_r, timeout_s;
    logic             mult_init_r;
    logic             rd_s, wr_s, start_s;
    logic [2:0]       reg_sel_s;
    logic             unused_s;

    assign reg_sel_s = addr[4:2];
    assign rd_s      = cs & rd;
    assign wr_s      = cs & wr;
    assign start_s   = wr_s & (reg_sel_s == REG_CTRL) & d_in[0];
    assign cnt_inc_s = cnt_r + CNT_ONE;
    assign unused_s  = &{1'b0, addr[1:0], d_in[31:16]};

    assign d_out     = d_out_r;
    assign mult_init = mult_init_r;
    assign mult_op_A = opa_r;
    assign mult_op_B = opb_r;

    // Read-data mux; values are sampled before this cycle's state update.
    always_comb begin
        rdata_s = 32'd0;
        case (reg_sel_s)
            REG_OPA:    rdata_s = {16'd0, opa_r};
            REG_OPB:    rdata_s = {16'd0, opb_r};
            REG_STATUS: rdata_s = {29'd0, timeout_r, done_r, busy_r};
            REG_RESULT: rdata_s = result_r;
            default:    rdata_s = 32'd0;
        endcase
    end

    // Operand registers are frozen while an operation is in flight.
    always_comb begin
        opa_s = opa_r;
        opb_s = opb_r;
        if (wr_s && !busy_r && (reg_sel_s == REG_OPA)) begin
            opa_s = d_in[15:0];
        end else if (wr_s && !busy_r && (reg_sel_s == REG_OPB)) begin
            opb_s = d_in[15:0];
        end else begin
            opa_s = opa_r;
            opb_s = opb_r;
        end
    end

    // Next-state and flag logic; completion takes priority over timeout.
    always_comb begin
        next_state_s = state_r;
        busy_s       = busy_r;
        done_s       = done_r;
        timeout_s    = timeout_r;
        cnt_s        = cnt_r;
        result_s     = result_r;
        case (state_r)
            ST_IDLE: begin
                if (start_s) begin
                    next_state_s = ST_LAUNCH;
                    busy_s       = 1'b1;
                    done_s       = 1'b0;
                    timeout_s    = 1'b0;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_LAUNCH: begin
                cnt_s        = CNT_ZERO;
                next_state_s = ST_WAIT;
            end
            ST_WAIT: begin
                cnt_s = cnt_inc_s;
                if (mult_done) begin
                    result_s     = mult_result;
                    done_s       = 1'b1;
                    next_state_s = ST_DRAIN;
                end else if (cnt_inc_s == CNT_MAX) begin
                    timeout_s    = 1'b1;
                    next_state_s = ST_DRAIN;
                end else begin
                    next_state_s = ST_WAIT;
                end
            end
            ST_DRAIN: begin
                if (mult_done) begin
                    next_state_s = ST_DRAIN;
                end else begin
                    busy_s       = 1'b0;
                    next_state_s = ST_IDLE;
                end
            end
            default: begin
                busy_s       = 1'b0;
                next_state_s = ST_IDLE;
            end
        endcase
    end

    // State, flag, operand and bus-read registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r     <= ST_IDLE;
            opa_r       <= 16'd0;
            opb_r       <= 16'd0;
            result_r    <= 32'd0;
            d_out_r     <= 32'd0;
            cnt_r       <= CNT_ZERO;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            timeout_r   <= 1'b0;
            mult_init_r <= 1'b0;
        end else begin
            state_r     <= next_state_s;
            opa_r       <= opa_s;
            opb_r       <= opb_s;
            result_r    <= result_s;
            cnt_r       <= cnt_s;
            busy_r      <= busy_s;
            done_r      <= done_s;
            timeout_r   <= timeout_s;
            mult_init_r <= (next_state_s == ST_LAUNCH);
            if (rd_s) begin
                d_out_r <= rdata_s;
            end else begin
                d_out_r <= d_out_r;
            end
        end
    end

`ifdef MULT_CTRL_IRQ_EN
    logic irq_r, irq_s;

    assign irq = irq_r;

    // Interrupt raised on entry to DRAIN, acknowledged by a STATUS read.
    always_comb begin
        irq_s = irq_r;
        if ((state_r == ST_WAIT) && (next_state_s == ST_DRAIN)) begin
            irq_s = 1'b1;
        end else if (rd_s && (reg_sel_s == REG_STATUS)) begin
            irq_s = 1'b0;
        end else begin
            irq_s = irq_r;
        end
    end

    // Interrupt register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            irq_r <= 1'b0;
        end else begin
            irq_r <= irq_s;
        end
    end
`endif

endmodule
